// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake between the external boot byte
// source and the instruction-memory loader.
//   in_valid : source has a byte on in_data
//   in_data  : stream byte
//   in_ready : loader accepts a byte this cycle
// A byte moves on a clock edge where in_valid and in_ready are both high.
// The master modport belongs to the byte source, the slave modport to the
// loader.
interface imem_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the processor's instruction memory.
// It reads a byte stream laid out as:
//   length byte L (0 means DEPTH words)
//   4*N data bytes, little-endian within each word
//   one checksum byte (XOR of all data bytes)
// It writes each assembled word to imem through the synchronous write port.
// The processor is held in reset until the image is complete and the
// checksum matches.
//
// Ports:
//   clk, reset   : clock and asynchronous active-high reset
//   in_bus       : byte stream, slave side (in_valid/in_data/in_ready)
//   mem_we       : one-cycle imem write strobe
//   mem_addr     : word address for the write
//   mem_wdata    : word data for the write
//   cpu_reset    : processor reset, released only after a good load
//   done         : image loaded and checksum verified
//   error        : bad length or checksum; terminal until reset
//   words_loaded : count of words committed to imem since reset
module imem_loader #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.slave  in_bus,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          cpu_reset,
  output logic          done,
  output logic          error,
  output logic [AW:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_SUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [AW-1:0] IDX_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   WL_ONE  = {{AW{1'b0}}, 1'b1};

  state_t        state;
  logic [1:0]    byte_idx;
  logic [AW-1:0] word_idx;
  logic [AW-1:0] last_idx;
  logic [7:0]    checksum;
  logic [23:0]   asm_word;

  logic          ready_int;
  logic          accept;
  logic [7:0]    len_m1;
  logic          len_too_big;

  // The loader takes bytes in every state that still expects stream input.
  // ready depends only on the state register, so it never drops in the
  // middle of the data phase.
  assign ready_int       = (state == S_LEN) || (state == S_DATA) || (state == S_SUM);
  assign in_bus.in_ready = ready_int;
  assign accept          = in_bus.in_valid && ready_int;

  // The length byte is turned into the index of the last word. That way
  // the data phase compares against an AW-bit value. A length of zero
  // wraps to 0xFF here, and that case is replaced by DEPTH-1 below.
  assign len_m1      = in_bus.in_data - 8'd1;
  assign len_too_big = int'(in_bus.in_data) > DEPTH;

  // Loader state machine and all registered outputs.
  // mem_we is a strobe that defaults low every cycle. It is raised for one
  // cycle after the fourth byte of a word, and mem_addr/mem_wdata are
  // loaded on that same edge. words_loaded counts on the edge where the
  // strobe is high, which is the edge where imem actually captures the
  // word. done and cpu_reset change only on the edge that accepts the
  // checksum byte. That edge is never earlier than the last word's write
  // edge, so the processor cannot leave reset before the image is
  // complete.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_LEN;
      byte_idx     <= 2'd0;
      word_idx     <= '0;
      last_idx     <= '0;
      checksum     <= 8'd0;
      asm_word     <= 24'd0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= 32'd0;
      cpu_reset    <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      mem_we <= 1'b0;
      if (mem_we) begin
        words_loaded <= words_loaded + WL_ONE;
      end

      case (state)
        S_LEN: begin
          if (accept) begin
            if (len_too_big) begin
              state <= S_ERR;
              error <= 1'b1;
            end else begin
              state    <= S_DATA;
              byte_idx <= 2'd0;
              word_idx <= '0;
              checksum <= 8'd0;
              last_idx <= (in_bus.in_data == 8'd0) ? AW'(DEPTH - 1) : len_m1[AW-1:0];
            end
          end
        end

        S_DATA: begin
          if (accept) begin
            checksum <= checksum ^ in_bus.in_data;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: asm_word[7:0]   <= in_bus.in_data;
              2'd1: asm_word[15:8]  <= in_bus.in_data;
              2'd2: asm_word[23:16] <= in_bus.in_data;
              default: begin
                mem_we    <= 1'b1;
                mem_addr  <= word_idx;
                mem_wdata <= {in_bus.in_data, asm_word};
                word_idx  <= word_idx + IDX_ONE;
                if (word_idx == last_idx) begin
                  state <= S_SUM;
                end
              end
            endcase
          end
        end

        S_SUM: begin
          if (accept) begin
            if (in_bus.in_data == checksum) begin
              state     <= S_DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
        end

        S_DONE, S_ERR: begin
        end

        default: begin
          state <= S_ERR;
          error <= 1'b1;
        end
      endcase
    end
  end

endmodule
